// File: rtl/freq_display_pkg.sv
// Shared types and constants for the frequency display:
// converter states, seven-segment codes and display limit.
package freq_display_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } conv_state_e;

    // Segment codes are {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam int unsigned MAX_DISPLAY = 9999;

    function automatic logic [6:0] seg_encode(input logic [3:0] nib);
        logic [6:0] s;
        unique case (nib)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Double-dabble correction: any BCD digit >= 5 gets +3 before the shift
    function automatic logic [15:0] dabble_adjust(input logic [15:0] acc);
        logic [15:0] r;
        r = acc;
        for (int i = 0; i < 4; i++) begin
            if (r[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/freq_display_bin2bcd_seq.sv
// Sequential 14-bit binary to 4-digit BCD converter (double-dabble),
// one bit per cycle; bcd only updates when a conversion completes.
module bin2bcd_seq
    import freq_display_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [13:0] bin,
    output logic        busy,
    output logic [15:0] bcd
);

    localparam logic [13:0] BIN_MAX = 14'(MAX_DISPLAY);
    localparam logic [3:0]  LAST_IT = 4'd13;

    conv_state_e state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [13:0] work_q, work_d;
    logic [15:0] acc_q, acc_d;
    logic [15:0] bcd_q, bcd_d;
    logic        busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        acc_d   = acc_q;
        bcd_d   = bcd_q;
        busy_d  = busy_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    work_d  = (bin > BIN_MAX) ? BIN_MAX : bin;
                    acc_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = CONV;
                end
            end
            CONV: begin
                {acc_d, work_d} = {dabble_adjust(acc_q), work_q} << 1;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LAST_IT) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                bcd_d   = acc_q;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
            acc_q   <= '0;
            bcd_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            acc_q   <= acc_d;
            bcd_q   <= bcd_d;
            busy_q  <= busy_d;
        end
    end

    assign busy = busy_q;
    assign bcd  = bcd_q;

endmodule

// File: rtl/freq_display.sv
// Four-digit multiplexed seven-segment display of a 14-bit frequency,
// converted to BCD on change and scanned one digit per refresh slot.
module freq_display
    import freq_display_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100_000,
    parameter bit          BLANK_LZ    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [13:0] frequency,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        dp,
    output logic [15:0] bcd,
    output logic        busy
);

    localparam int unsigned DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

    logic [13:0]      last_value_q, last_value_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             start;
    logic             conv_busy;
    logic [15:0]      conv_bcd;
    logic [3:0]       nib;
    logic             blank;

    // Converter is idle exactly when busy is low, so a new start is only
    // issued between conversions and always uses the latest frequency
    assign start = !conv_busy && (frequency != last_value_q);

    bin2bcd_seq u_conv (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (frequency),
        .busy  (conv_busy),
        .bcd   (conv_bcd)
    );

    always_comb begin
        last_value_d = start ? frequency : last_value_q;
        div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        idx_d = (div_q == DIV_LAST) ? idx_q + 2'd1 : idx_q;
    end

    always_comb begin
        nib   = conv_bcd[3:0];
        blank = 1'b0;
        unique case (idx_q)
            2'd0: begin
                nib   = conv_bcd[3:0];
                blank = 1'b0;
            end
            2'd1: begin
                nib   = conv_bcd[7:4];
                blank = (conv_bcd[15:4] == 12'd0);
            end
            2'd2: begin
                nib   = conv_bcd[11:8];
                blank = (conv_bcd[15:8] == 8'd0);
            end
            2'd3: begin
                nib   = conv_bcd[15:12];
                blank = (conv_bcd[15:12] == 4'd0);
            end
            default: begin
                nib   = conv_bcd[3:0];
                blank = 1'b0;
            end
        endcase
        an_d  = ~(4'b0001 << idx_q);
        seg_d = (BLANK_LZ && blank) ? SEG_BLANK : seg_encode(nib);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_value_q <= '0;
            div_q        <= '0;
            idx_q        <= '0;
            an_q         <= 4'b1111;
            seg_q        <= SEG_BLANK;
        end else begin
            last_value_q <= last_value_d;
            div_q        <= div_d;
            idx_q        <= idx_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
        end
    end

    assign an   = an_q;
    assign seg  = seg_q;
    assign dp   = 1'b1;
    assign bcd  = conv_bcd;
    assign busy = conv_busy;

endmodule

// File: tb/tb_freq_display.sv
// Randomized and directed bench for freq_display against a
// decimal-arithmetic reference of the displayed value.
module tb_freq_display;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [13:0] frequency = '0;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        dp;
    logic [15:0] bcd;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;
    logic [15:0] cur_bcd = '0;

    always #5 clk = ~clk;

    freq_display #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .frequency (frequency),
        .seg       (seg),
        .an        (an),
        .dp        (dp),
        .bcd       (bcd),
        .busy      (busy)
    );

    function automatic logic [15:0] model_bcd(input int f);
        int v;
        v = (f > 9999) ? 9999 : f;
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [6:0] model_seg(input logic [15:0] b, input int d);
        logic [6:0] tbl [10];
        int val;
        int upper;
        tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        upper = int'(b) >> (4 * d);
        val   = upper % 16;
        if (d > 0 && upper == 0) return 7'b1111111;
        return tbl[val];
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drive f; next edge is the capture edge. Optionally change input mid-run.
    task automatic run_conv(input int f, input int mid_f, input int mid_at, input string name);
        int n;
        logic [15:0] old;
        old = cur_bcd;
        frequency = 14'(f);
        n = 0;
        tick;
        n_chk++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s busy_rise: got %b expected 1", name, busy);
        end
        while (busy === 1'b1 && n < 40) begin
            n++;
            n_chk++;
            if (bcd !== old) begin
                n_fail++;
                $display("FAIL %s no_partial: got %h expected %h", name, bcd, old);
            end
            if (mid_f >= 0 && n == mid_at) frequency = 14'(mid_f);
            tick;
        end
        n_chk++;
        if (n != 15) begin
            n_fail++;
            $display("FAIL %s busy_len: got %0d expected 15", name, n);
        end
        cur_bcd = model_bcd(f);
        n_chk++;
        if (bcd !== cur_bcd) begin
            n_fail++;
            $display("FAIL %s bcd: got %h expected %h", name, bcd, cur_bcd);
        end
    endtask

    task automatic check_display(input string name);
        logic [3:0] seen;
        int d;
        seen = '0;
        tick;
        repeat (20) begin
            tick;
            d = -1;
            for (int k = 0; k < 4; k++) begin
                if (an === ~(4'b0001 << k)) d = k;
            end
            n_chk++;
            if (d < 0) begin
                n_fail++;
                $display("FAIL %s an_onehot: got %b expected one low bit", name, an);
            end else begin
                seen[d] = 1'b1;
                n_chk++;
                if (seg !== model_seg(cur_bcd, d)) begin
                    n_fail++;
                    $display("FAIL %s seg_d%0d: got %b expected %b",
                             name, d, seg, model_seg(cur_bcd, d));
                end
            end
            n_chk++;
            if (dp !== 1'b1 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL %s dp_busy: got %b%b expected 10", name, dp, busy);
            end
        end
        n_chk++;
        if (seen !== 4'hf) begin
            n_fail++;
            $display("FAIL %s digits_seen: got %b expected 1111", name, seen);
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        frequency = '0;
        repeat (3) tick;
        n_chk++;
        if ({an, seg, dp, bcd, busy} !== {4'b1111, 7'b1111111, 1'b1, 16'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_vals: got an=%b seg=%b dp=%b bcd=%h busy=%b expected 1111 1111111 1 0000 0",
                     an, seg, dp, bcd, busy);
        end
        cur_bcd = '0;
    endtask

    // Release reset with frequency 0: no conversion, scan steps every 4 cycles
    task automatic test_scan_after_reset;
        logic [3:0] exp_an;
        rst = 1'b1;
        for (int e = 1; e <= 24; e++) begin
            tick;
            exp_an = ~(4'b0001 << (((e - 1) / 4) % 4));
            n_chk++;
            if (an !== exp_an) begin
                n_fail++;
                $display("FAIL scan_an e%0d: got %b expected %b", e, an, exp_an);
            end
            n_chk++;
            if (seg !== model_seg(16'h0, ((e - 1) / 4) % 4)) begin
                n_fail++;
                $display("FAIL scan_seg e%0d: got %b expected %b",
                         e, seg, model_seg(16'h0, ((e - 1) / 4) % 4));
            end
            n_chk++;
            if (busy !== 1'b0) begin
                n_fail++;
                $display("FAIL zero_no_busy e%0d: got %b expected 0", e, busy);
            end
        end
    endtask

    task automatic test_basic;
        run_conv(1234, -1, 0, "conv1234");
        check_display("disp1234");
        run_conv(12000, -1, 0, "clamp12000");
        check_display("disp9999");
        run_conv(9999, -1, 0, "max9999");
        run_conv(10000, -1, 0, "clamp10000");
        run_conv(0, -1, 0, "back_to_0");
        check_display("disp0");
    endtask

    task automatic test_back_to_back;
        run_conv(5, 7, 3, "first5");
        run_conv(7, -1, 0, "second7");
        check_display("disp7");
    endtask

    task automatic test_same_value;
        repeat (5) begin
            tick;
            n_chk++;
            if (busy !== 1'b0 || bcd !== cur_bcd) begin
                n_fail++;
                $display("FAIL same_value: got busy=%b bcd=%h expected 0 %h", busy, bcd, cur_bcd);
            end
        end
    endtask

    task automatic test_reset_abort;
        frequency = 14'd4096;
        tick;
        n_chk++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_start: got %b expected 1", busy);
        end
        repeat (7) tick;
        rst = 1'b0;
        #1;
        n_chk++;
        if ({an, seg, dp, bcd, busy} !== {4'b1111, 7'b1111111, 1'b1, 16'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL abort_async: got an=%b seg=%b dp=%b bcd=%h busy=%b expected 1111 1111111 1 0000 0",
                     an, seg, dp, bcd, busy);
        end
        cur_bcd = '0;
        tick;
        n_chk++;
        if (busy !== 1'b0 || bcd !== 16'h0) begin
            n_fail++;
            $display("FAIL abort_hold: got busy=%b bcd=%h expected 0 0000", busy, bcd);
        end
        rst = 1'b1;
        run_conv(4096, -1, 0, "after_abort");
        check_display("disp4096");
    endtask

    task automatic test_random;
        int f;
        int last;
        last = 4096;
        for (int i = 0; i < 8; i++) begin
            f = int'($urandom_range(0, 16383));
            if (i % 3 == 0) f = int'($urandom_range(0, 9999));
            if (f == last) f = (f + 1) % 16384;
            run_conv(f, -1, 0, $sformatf("rand%0d_%0d", i, f));
            if (i % 2 == 0) check_display($sformatf("rdisp%0d", i));
            last = f;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_scan_after_reset;
        check_display("disp_zero");
        test_basic;
        test_back_to_back;
        test_same_value;
        test_reset_abort;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
